// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC owner, IR holder, req/ack fetch from memory.
// Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 64,
    parameter int PC_STEP = 1,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              R,
    input  logic [15:0]       T,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] in_bus,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_busy,
    output logic              fetch_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_ack_fire;
    logic                w_abort;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_pend_pc;
    logic                r_pend_valid;
    logic [DATA_W-1:0]   r_ir;
    logic                w_unused_t;

    // Only slot T[0] starts a fetch; the other slots belong to other units.
    assign w_unused_t = ^T[15:1];

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic                w_tmo;

    assign w_tmo = (r_cnt == CNT_W'(TIMEOUT - 1));
`else
    logic                w_tmo;

    assign w_tmo = 1'b0;
`endif

    // State register; reset drops mem_req at once since it decodes from state.
    always_ff @(posedge clk or negedge R) begin
        if (!R) r_state <= IDLE;
        else    r_state <= w_state_nxt;
    end

    // Next state; an ack on the timeout cycle counts as normal completion.
    always_comb begin
        w_state_nxt = r_state;
        w_ack_fire  = 1'b0;
        w_abort     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (T[0]) w_state_nxt = REQ;
            end
            REQ: begin
                if (mem_ack) begin
                    w_state_nxt = IDLE;
                    w_ack_fire  = 1'b1;
                end else if (w_tmo) begin
                    w_state_nxt = IDLE;
                    w_abort     = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // PC, pending branch target and IR updates.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            r_pc         <= '0;
            r_pend_pc    <= '0;
            r_pend_valid <= 1'b0;
            r_ir         <= '0;
        end else if (w_ack_fire) begin
            r_ir         <= mem_rdata;
            r_pend_valid <= 1'b0;
            if (pc_load)           r_pc <= pc_in;
            else if (r_pend_valid) r_pc <= r_pend_pc;
            else                   r_pc <= r_pc + ADDR_W'(PC_STEP);
        end else if (w_abort) begin
            r_ir         <= '0;
            r_pend_valid <= 1'b0;
        end else if (pc_load) begin
            if (r_state == IDLE) begin
                r_pc <= pc_in;
            end else begin
                r_pend_pc    <= pc_in;
                r_pend_valid <= 1'b1;
            end
        end
    end

`ifdef FETCH_TIMEOUT_EN
    // Cycle counter for the current request; zero on the first REQ cycle.
    always_ff @(posedge clk or negedge R) begin
        if (!R)                 r_cnt <= '0;
        else if (r_state == REQ) r_cnt <= r_cnt + 1'b1;
        else                    r_cnt <= '0;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or negedge R) begin
        if (!R)          r_err <= 1'b0;
        else if (w_abort) r_err <= 1'b1;
    end

    assign fetch_err = r_err;
`else
    assign fetch_err = 1'b0;
`endif

    assign mem_req    = (r_state == REQ);
    assign fetch_busy = (r_state == REQ);
    assign mem_addr   = r_pc;
    assign pc         = r_pc;
    assign in_bus     = r_ir;

endmodule
